// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: hysteresis/debounced 3-sensor line follower driving a two-motor H-bridge with PWM, node counting and lost-line stop.
module line_follow_ctrl #(
    parameter int SENSOR_W     = 13,
    parameter int THRESH       = 1023,
    parameter int HYST         = 32,
    parameter int DEBOUNCE     = 4,
    parameter int PWM_W        = 8,
    parameter int FWD_DUTY     = 200,
    parameter int TURN_DUTY    = 120,
    parameter int NODE_HOLD    = 64,
    parameter int LOST_TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [SENSOR_W-1:0] sensorL,
    input  logic [SENSOR_W-1:0] sensorC,
    input  logic [SENSOR_W-1:0] sensorR,
    output logic                AF,
    output logic                AB,
    output logic                BF,
    output logic                BB,
    output logic                node_pulse,
    output logic [1:0]          node_side,
    output logic [7:0]          node_count,
    output logic                lost,
    output logic [2:0]          state
);
    typedef enum logic [2:0] {IDLE = 3'd0, FOLLOW = 3'd1, NODE = 3'd2, LOST = 3'd3, STOP = 3'd4} state_t;
    localparam logic [SENSOR_W-1:0] LO = SENSOR_W'(THRESH - HYST);
    localparam logic [SENSOR_W-1:0] HI = SENSOR_W'(THRESH + HYST);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE - 1);
    localparam int TMAX = NODE_HOLD > LOST_TIMEOUT ? NODE_HOLD : LOST_TIMEOUT;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [TW-1:0] NODE_END = TW'(NODE_HOLD - 1);
    localparam logic [TW-1:0] LOST_END = TW'(LOST_TIMEOUT - 1);
    // duty carries one extra bit so a duty of 2^PWM_W means always on
    localparam int DW = PWM_W + 1;
    localparam logic [DW-1:0] FWD = DW'(FWD_DUTY);
    localparam logic [DW-1:0] TURN = DW'(TURN_DUTY);

    state_t           state_q, state_d;
    logic [2:0]       det_q, det_d, a_q, a_d;
    logic [DBW-1:0]   db_q, db_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [DW-1:0]    duty_a_q, duty_a_d, duty_b_q, duty_b_d;
    logic             arm_q, arm_d, pulse_q, pulse_d, lost_q, lost_d;
    logic             af_q, af_d, bf_q, bf_d;
    logic [1:0]       side_q, side_d;
    logic [7:0]       count_q, count_d;
    logic             stable, node_pat;

    function automatic logic hyst(input logic [SENSOR_W-1:0] s, input logic d);
        return (s < LO) ? 1'b1 : (s >= HI) ? 1'b0 : d;
    endfunction

    always_comb begin
        det_d    = {hyst(sensorL, det_q[2]), hyst(sensorC, det_q[1]), hyst(sensorR, det_q[0])};
        stable   = det_d == det_q;
        db_d     = !stable ? '0 : (db_q == DB_MAX) ? db_q : db_q + 1'b1;
        a_d      = (stable && db_q == DB_MAX) ? det_q : a_q;
        pwm_d    = pwm_q + 1'b1;
        node_pat = a_q == 3'b110 || a_q == 3'b011 || a_q == 3'b111;
        state_d  = state_q;
        tmr_d    = tmr_q;
        duty_a_d = duty_a_q;
        duty_b_d = duty_b_q;
        pulse_d  = 1'b0;
        side_d   = side_q;
        count_d  = count_q;
        arm_d    = node_pat ? arm_q : 1'b1;
        if (!enable) begin
            state_d  = IDLE;
            tmr_d    = '0;
            duty_a_d = '0;
            duty_b_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FOLLOW;
                    tmr_d   = '0;
                end
                FOLLOW: begin
                    if (node_pat) begin
                        duty_a_d = FWD;
                        duty_b_d = FWD;
                        // arm_q keeps one physical node from being counted more than once
                        if (arm_q) begin
                            state_d = NODE;
                            pulse_d = 1'b1;
                            side_d  = {a_q[2], a_q[0]};
                            count_d = &count_q ? count_q : count_q + 8'd1;
                            arm_d   = 1'b0;
                            tmr_d   = '0;
                        end
                    end else if (a_q == 3'b000) begin
                        state_d = LOST;
                        tmr_d   = '0;
                    end else begin
                        duty_a_d = a_q == 3'b100 ? '0 : a_q == 3'b001 ? TURN : FWD;
                        duty_b_d = a_q == 3'b100 ? TURN : a_q == 3'b001 ? '0 : FWD;
                    end
                end
                NODE: begin
                    state_d = tmr_q == NODE_END ? FOLLOW : NODE;
                    tmr_d   = tmr_q == NODE_END ? '0 : tmr_q + 1'b1;
                end
                LOST: begin
                    if (a_q != 3'b000) begin
                        state_d = FOLLOW;
                        tmr_d   = '0;
                    end else if (tmr_q == LOST_END) begin
                        state_d  = STOP;
                        tmr_d    = '0;
                        duty_a_d = '0;
                        duty_b_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    duty_a_d = '0;
                    duty_b_d = '0;
                end
            endcase
        end
        lost_d = state_d == STOP;
        af_d   = {1'b0, pwm_q} < duty_a_d;
        bf_d   = {1'b0, pwm_q} < duty_b_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            det_q    <= '0;
            a_q      <= '0;
            db_q     <= '0;
            pwm_q    <= '0;
            tmr_q    <= '0;
            duty_a_q <= '0;
            duty_b_q <= '0;
            arm_q    <= 1'b1;
            pulse_q  <= 1'b0;
            side_q   <= '0;
            count_q  <= '0;
            lost_q   <= 1'b0;
            af_q     <= 1'b0;
            bf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            a_q      <= a_d;
            db_q     <= db_d;
            pwm_q    <= pwm_d;
            tmr_q    <= tmr_d;
            duty_a_q <= duty_a_d;
            duty_b_q <= duty_b_d;
            arm_q    <= arm_d;
            pulse_q  <= pulse_d;
            side_q   <= side_d;
            count_q  <= count_d;
            lost_q   <= lost_d;
            af_q     <= af_d;
            bf_q     <= bf_d;
        end
    end

    assign AF         = af_q;
    assign BF         = bf_q;
    assign AB         = 1'b0;
    assign BB         = 1'b0;
    assign node_pulse = pulse_q;
    assign node_side  = side_q;
    assign node_count = count_q;
    assign lost       = lost_q;
    assign state      = state_q;
endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: directed and random stimulus checked against a cycle-level behavioural model of the line follower.
module tb_line_follow_ctrl;
    localparam int TH = 1023, HY = 32, DB = 4, FWD = 200, TRN = 120, NH = 64, LT = 16;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic [12:0] sL, sC, sR;
    logic        AF, AB, BF, BB, node_pulse, lost;
    logic [1:0]  node_side;
    logic [7:0]  node_count;
    logic [2:0]  state;

    int n_chk = 0, n_err = 0;

    int       m_state, m_in, m_cnt, m_da, m_db, m_ph;
    bit       m_arm, m_pulse, m_af, m_bf;
    bit [1:0] m_side;
    logic [2:0] m_det, m_a;
    logic [2:0] hist[$];

    line_follow_ctrl #(.LOST_TIMEOUT(LT)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .sensorL(sL), .sensorC(sC), .sensorR(sR),
        .AF(AF), .AB(AB), .BF(BF), .BB(BB),
        .node_pulse(node_pulse), .node_side(node_side), .node_count(node_count),
        .lost(lost), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hyst(input int s, input bit d);
        if (s < TH - HY) return 1'b1;
        if (s >= TH + HY) return 1'b0;
        return d;
    endfunction

    task automatic model_edge();
        logic [2:0] nd, olda;
        int prev;
        bit node, stable, narm;
        if (reset) begin
            m_state = 0; m_in = 1; m_cnt = 0; m_da = 0; m_db = 0; m_ph = 0;
            m_arm = 1; m_pulse = 0; m_af = 0; m_bf = 0; m_side = 0;
            m_det = 0; m_a = 0;
            hist.delete();
            hist.push_back(3'b000);
            return;
        end
        nd = {hyst(sL, m_det[2]), hyst(sC, m_det[1]), hyst(sR, m_det[0])};
        hist.push_back(nd);
        if (hist.size() > DB + 1) void'(hist.pop_front());
        stable = hist.size() == DB + 1;
        foreach (hist[i]) if (hist[i] != nd) stable = 0;
        olda = m_a;
        if (stable) m_a = nd;
        m_det = nd;
        node = olda inside {3'b110, 3'b011, 3'b111};
        narm = node ? m_arm : 1'b1;
        prev = m_state;
        m_pulse = 0;
        if (!enable) begin
            m_state = 0; m_da = 0; m_db = 0;
        end else begin
            case (prev)
                0: m_state = 1;
                1: begin
                    if (node) begin
                        m_da = FWD; m_db = FWD;
                        if (m_arm) begin
                            m_state = 2; m_pulse = 1; m_side = {olda[2], olda[0]};
                            m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
                            narm = 0;
                        end
                    end else if (olda == 3'b000) m_state = 3;
                    else if (olda == 3'b100) begin m_da = 0; m_db = TRN; end
                    else if (olda == 3'b001) begin m_da = TRN; m_db = 0; end
                    else begin m_da = FWD; m_db = FWD; end
                end
                2: if (m_in == NH) m_state = 1;
                3: begin
                    if (olda != 3'b000) m_state = 1;
                    else if (m_in == LT) begin m_state = 4; m_da = 0; m_db = 0; end
                end
                default: ;
            endcase
        end
        m_arm = narm;
        m_in = (m_state != prev) ? 1 : m_in + 1;
        m_af = m_ph < m_da;
        m_bf = m_ph < m_db;
        m_ph = (m_ph + 1) % 256;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        chk("state", state, m_state);
        chk("node", {node_pulse, node_side, node_count}, {m_pulse, m_side, m_cnt[7:0]});
        chk("lost", lost, m_state == 4);
        chk("motor", {AF, AB, BF, BB}, {m_af, 1'b0, m_bf, 1'b0});
    endtask

    task automatic set_pat(input logic [2:0] p);
        sL = p[2] ? 13'd900 : 13'd2000;
        sC = p[1] ? 13'd900 : 13'd2000;
        sR = p[0] ? 13'd900 : 13'd2000;
    endtask

    function automatic logic [12:0] rnd_val(input bit dark);
        if ($urandom_range(0, 7) == 0) return 13'($urandom_range(TH - HY, TH + HY - 1));
        return dark ? 13'($urandom_range(0, TH - HY - 1)) : 13'($urandom_range(TH + HY, 8191));
    endfunction

    task automatic wait_state(input int s, input int lim, input string tag);
        int k = 0;
        while (state !== 3'(s) && k < lim) begin step(); k++; end
        chk(tag, state, s);
    endtask

    task automatic duty_window(output int na, output int nb);
        na = 0; nb = 0;
        repeat (256) begin step(); na += int'(AF); nb += int'(BF); end
    endtask

    initial begin
        int na, nb, n, np, nn, k;
        bit seen_stop;
        logic [2:0] p;
        reset = 1; enable = 1; set_pat(3'b010);
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_outs", {AF, AB, BF, BB, node_pulse, node_side, node_count, lost}, 0);
        reset = 0;
        step();
        chk("rst_follow", state, 1);
        repeat (20) step();
        chk("first_follow", state, 1);
        duty_window(na, nb);
        chk("fwd_duty_a", na, 200);
        chk("fwd_duty_b", nb, 200);
        sC = 13'd1040;
        repeat (30) step();
        chk("band_hold", state, 1);
        duty_window(na, nb);
        chk("band_duty_a", na, 200);
        set_pat(3'b100);
        repeat (10) step();
        duty_window(na, nb);
        chk("turn_a", na, 0);
        chk("turn_b", nb, 120);
        set_pat(3'b000);
        wait_state(3, 20, "to_lost");
        n = 1;
        sC = 13'd900;
        repeat (3) begin step(); n += int'(state == 3'd3); end
        sC = 13'd2000;
        while (state == 3'd3 && n < 100) begin step(); if (state == 3'd3) n++; end
        chk("lost_len", n, LT);
        chk("stop_state", state, 4);
        chk("stop_lost", lost, 1);
        chk("stop_motor", {AF, BF}, 0);
        enable = 0;
        step();
        chk("dis_idle", state, 0);
        enable = 1; set_pat(3'b010);
        repeat (20) step();
        chk("refollow", state, 1);
        set_pat(3'b000);
        wait_state(3, 20, "to_lost2");
        repeat (5) step();
        set_pat(3'b010);
        k = 0; seen_stop = 0;
        while (state !== 3'd1 && k < 30) begin step(); k++; if (state == 3'd4) seen_stop = 1; end
        chk("recover", state, 1);
        chk("no_stop", seen_stop, 0);
        repeat (20) step();
        set_pat(3'b110);
        np = 0; nn = 0;
        repeat (200) begin step(); np += int'(node_pulse); nn += int'(state == 3'd2); end
        chk("n1_pulses", np, 1);
        chk("n1_len", nn, NH);
        chk("n1_side", node_side, 2'b10);
        chk("n1_cnt", node_count, 1);
        set_pat(3'b010);
        repeat (20) step();
        set_pat(3'b011);
        repeat (100) step();
        chk("n2_side", node_side, 2'b01);
        chk("n2_cnt", node_count, 2);
        set_pat(3'b010);
        repeat (20) step();
        repeat (256) begin
            set_pat(3'b110);
            repeat (75) step();
            set_pat(3'b010);
            repeat (10) step();
        end
        chk("sat_cnt", node_count, 255);
        set_pat(3'b110);
        wait_state(2, 30, "mid_node");
        repeat (10) step();
        reset = 1;
        step();
        chk("mid_rst_cnt", node_count, 0);
        chk("mid_rst_state", state, 0);
        reset = 0;
        repeat (250) begin
            p = 3'($urandom_range(0, 7));
            enable = $urandom_range(0, 15) != 0;
            if ($urandom_range(0, 40) == 0) begin reset = 1; repeat (2) step(); reset = 0; end
            repeat ($urandom_range(1, 100)) begin
                sL = rnd_val(p[2]); sC = rnd_val(p[1]); sR = rnd_val(p[0]);
                step();
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
